hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core: load-use stall detection, EX-stage operand forwarding selects, control-hazard flush, and the ecall halt sequence.
- Drives the PC write-enable, the IF/ID write-enable and flush, the ID/EX bubble insert, and the CPU's is_halted.
- Holds the halt FSM and two 32-bit performance counters.
- Sits beside the control unit and sees only pipeline-register fields.

Parameters:
- XLEN, 32, data width of the x17 value paths and the counters.
- DRAIN_CYCLES, 3, cycles spent draining older instructions after a halting ecall.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- id_is_ecall  in  1  ecall decoded in ID
- rf_x17  in  XLEN  register-file read of x17
- id_ex_rs1, id_ex_rs2, id_ex_rd  in  5  ID/EX register fields
- id_ex_mem_read, id_ex_reg_write  in  1  ID/EX control bits
- ex_mem_rd  in  5  EX/MEM destination register
- ex_mem_reg_write, ex_mem_mem_read  in  1  EX/MEM control bits
- ex_mem_alu_out  in  XLEN  EX/MEM ALU result
- mem_wb_rd  in  5  MEM/WB destination register
- mem_wb_reg_write  in  1  MEM/WB write enable
- mem_wb_wdata  in  XLEN  final writeback value
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  zero ID/EX control bits
- forward_a, forward_b  out  2  ALU operand select: 00 = ID/EX data, 10 = EX/MEM, 01 = MEM/WB
- is_halted  out  1  simulation finished
- stall_count, flush_count  out  XLEN  performance counters

Behaviour:
- Reset: state = RUN, drain counter = 0, is_halted = 0, both counters = 0.
- Reset: combinational outputs settle to pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0, forward = 00.
- Reset asserted mid-drain or while HALTED returns to RUN on the next edge.

Forwarding (combinational, all states):
- forward_a = 10 if ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == id_ex_rs1.
- Otherwise forward_a = 01 if mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == id_ex_rs1.
- Otherwise forward_a = 00.
- forward_b is computed the same way against id_ex_rs2.
- x0 is never forwarded.

Load-use hazard:
- load_use = id_ex_mem_read && id_ex_rd != 0 && ((id_use_rs1 && id_ex_rd == id_rs1) || (id_use_rs2 && id_ex_rd == id_rs2)).

Ecall hazard:
- ecall_stall = id_is_ecall && ((id_ex_reg_write && id_ex_rd == 17) || (ex_mem_mem_read && ex_mem_rd == 17)).

Resolved x17 value, first match wins:
- ex_mem_alu_out if ex_mem_reg_write && ex_mem_rd == 17.
- else mem_wb_wdata if mem_wb_reg_write && mem_wb_rd == 17.
- else rf_x17.

Halt trigger:
- halt_req = id_is_ecall && !ecall_stall && !ex_redirect && x17 == 10.

FSM (registered state, RUN / DRAIN / HALTED):
- RUN, priority order:
  1. ex_redirect: if_id_flush = 1 and id_ex_bubble = 1; pc_write = 1 so the target loads; flush_count += 1. An ecall in ID this cycle is discarded.
  2. load_use or ecall_stall: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stall_count += 1.
  3. halt_req: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; next state = DRAIN, counter = DRAIN_CYCLES - 1.
- DRAIN: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; counter decrements each cycle.
- DRAIN at counter == 0: next state = HALTED.
- HALTED: same freeze outputs as DRAIN; is_halted = 1, sticky until reset.
- is_halted is registered and rises on the edge entering HALTED, i.e. DRAIN_CYCLES + 1 edges after the halt_req cycle.
- Counters increment only in RUN, wrap modulo 2^XLEN, and are frozen in DRAIN and HALTED.
- A non-10 x17 ecall is a NOP for this block.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_NONE = 2'b00, FWD_MEM_WB = 2'b01, FWD_EX_MEM = 2'b10
  - state enum RUN / DRAIN / HALTED
  - REG_X17 = 5'd17, HALT_CODE = 10
- One sub-module, forwarding_unit: purely combinational, instantiated once, produces forward_a and forward_b.
- The FSM, hazard detection and counters stay in hazard_ctrl.

Test Plan:
- Load-use: ID/EX lw x5 (mem_read = 1, rd = 5), ID add reads rs1 = 5 -> one cycle with pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stall_count goes 0 -> 1; next cycle all clear.
- Forward priority: ex_mem_rd = mem_wb_rd = id_ex_rs1 = 7, both reg_write = 1 -> forward_a = 10. The same case with rd = 0 -> forward_a = 00.
- Redirect vs stall: ex_redirect = 1 together with a load_use condition -> if_id_flush = 1, pc_write = 1; flush_count = 1, stall_count unchanged.
- Halt: ecall in ID, rf_x17 = 10, no hazards -> DRAIN for 3 cycles; is_halted = 1 exactly 4 edges later and remains 1 for 20 cycles.
- Ecall dependency:
  - ID/EX addi x17 with rd = 17, reg_write = 1, and ecall in ID -> 1 stall cycle.
  - Next cycle ex_mem_alu_out = 10 -> halt taken.
  - Repeat with ex_mem_alu_out = 93 -> no halt.
- Reset mid-drain: assert reset during the 2nd DRAIN cycle -> next edge state = RUN, is_halted = 0, counters = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline sequencer: forwarding selects,
// halt FSM states, and the ecall halt convention (x17 == 10).
package cpu_pkg;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0] REG_X17   = 5'd17;
    localparam int         HALT_CODE = 10;

    // Operand source for one ALU input; the younger EX/MEM result beats
    // MEM/WB, and x0 is never forwarded because it is hardwired to zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] ex_mem_rd,
        input logic       ex_mem_reg_write,
        input logic [4:0] mem_wb_rd,
        input logic       mem_wb_reg_write
    );
        if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs))
            return FWD_EX_MEM;
        else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs))
            return FWD_MEM_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_forwarding_unit.sv
// EX-stage operand forwarding selects for both ALU inputs.
module forwarding_unit
    import cpu_pkg::*;
(
    input  logic [4:0] id_ex_rs1,
    input  logic [4:0] id_ex_rs2,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_reg_write,
    input  logic [4:0] mem_wb_rd,
    input  logic       mem_wb_reg_write,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    logic [4:0] src_rs  [2];
    logic [1:0] src_fwd [2];

    assign src_rs[0] = id_ex_rs1;
    assign src_rs[1] = id_ex_rs2;

    // Both operands use the identical priority rule.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign src_fwd[gi] = fwd_sel(src_rs[gi], ex_mem_rd, ex_mem_reg_write,
                                         mem_wb_rd, mem_wb_reg_write);
        end
    endgenerate

    assign forward_a = src_fwd[0];
    assign forward_b = src_fwd[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use / ecall stalls, branch flush, forwarding,
// the ecall halt drain sequence and stall/flush performance counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_is_ecall,
    input  logic [XLEN-1:0] rf_x17,
    input  logic [4:0]      id_ex_rs1,
    input  logic [4:0]      id_ex_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic            id_ex_mem_read,
    input  logic            id_ex_reg_write,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic            ex_mem_mem_read,
    input  logic [XLEN-1:0] ex_mem_alu_out,
    input  logic [4:0]      mem_wb_rd,
    input  logic            mem_wb_reg_write,
    input  logic [XLEN-1:0] mem_wb_wdata,
    input  logic            ex_redirect,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_bubble,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic            is_halted,
    output logic [XLEN-1:0] stall_count,
    output logic [XLEN-1:0] flush_count
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t          state_reg;
    logic [CW-1:0]   drain_cnt_reg;
    logic            is_halted_reg;
    logic [XLEN-1:0] stall_count_reg;
    logic [XLEN-1:0] flush_count_reg;

    logic            load_use;
    logic            ecall_stall;
    logic [XLEN-1:0] x17_value;
    logic            halt_req;

    forwarding_unit u_forwarding_unit (
        .id_ex_rs1        (id_ex_rs1),
        .id_ex_rs2        (id_ex_rs2),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .forward_a        (forward_a),
        .forward_b        (forward_b)
    );

    // Hazard detection and the x17 value the ecall in ID would observe.
    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_ex_rd == id_rs1)) ||
                    (id_use_rs2 && (id_ex_rd == id_rs2)));

        // x17 still being produced by an ALU op in EX or a load in MEM
        // cannot be resolved yet, so the ecall must wait.
        ecall_stall = id_is_ecall &&
                      ((id_ex_reg_write && (id_ex_rd == REG_X17)) ||
                       (ex_mem_mem_read && (ex_mem_rd == REG_X17)));

        if (ex_mem_reg_write && (ex_mem_rd == REG_X17))
            x17_value = ex_mem_alu_out;
        else if (mem_wb_reg_write && (mem_wb_rd == REG_X17))
            x17_value = mem_wb_wdata;
        else
            x17_value = rf_x17;

        halt_req = id_is_ecall && !ecall_stall && !ex_redirect &&
                   (x17_value == XLEN'(HALT_CODE));
    end

    // Pipeline enables: redirect beats stalls, stalls beat the halt request.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (state_reg == RUN) begin
            if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use || ecall_stall || halt_req) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Halt FSM, drain counter, sticky halted flag and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            drain_cnt_reg   <= '0;
            is_halted_reg   <= 1'b0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ex_redirect) begin
                        flush_count_reg <= flush_count_reg + 1'b1;
                    end else if (load_use || ecall_stall) begin
                        stall_count_reg <= stall_count_reg + 1'b1;
                    end else if (halt_req) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= CW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state_reg     <= HALTED;
                        is_halted_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    end
                end
                HALTED: begin
                    is_halted_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign is_halted   = is_halted_reg;
    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule
